cacheline_mem_arbiter_n: RTL and testbench

//  N-port arbiter merging cache-miss traffic (I$, D$, prefetcher, ...) onto one cacheline memory port.

---
 rtl/cacheline_mem_arbiter_n_pkg.sv | 12 +
 rtl/cacheline_mem_arbiter_n_if.sv | 32 +++
 rtl/cacheline_mem_arbiter_n_picker.sv | 41 ++++
 rtl/cacheline_mem_arbiter_n.sv | 111 +++++++++++
 tb/tb_cacheline_mem_arbiter_n.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cacheline_mem_arbiter_n_pkg.sv
// rtl/cacheline_mem_arbiter_n_pkg.sv - shared types for the cacheline memory arbiter
package cacheline_mem_arbiter_n_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DRAIN} arb_state_e;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  // Index width for a port count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cacheline_mem_arbiter_n_if.sv
// rtl/cacheline_mem_arbiter_n_if.sv - requester and memory-side buses of the arbiter
interface cacheline_mem_arbiter_n_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
);
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]           resp_rdata;
  logic [NUM_PORTS-1:0]        resp_valid;
  logic [ADDR_W-1:0]           cla_addr;
  logic                        cla_read;
  logic                        cla_write;
  logic [LINE_W-1:0]           cla_wdata;
  logic [LINE_W-1:0]           cla_rdata;
  logic [ADDR_W-1:0]           cla_raddr;
  logic                        cla_resp;

  // Environment side: caches plus the cacheline adapter.
  modport master (
    output req_addr, req_read, req_write, req_wdata, cla_rdata, cla_raddr, cla_resp,
    input  resp_rdata, resp_valid, cla_addr, cla_read, cla_write, cla_wdata
  );

  // Arbiter side.
  modport slave (
    input  req_addr, req_read, req_write, req_wdata, cla_rdata, cla_raddr, cla_resp,
    output resp_rdata, resp_valid, cla_addr, cla_read, cla_write, cla_wdata
  );
endinterface

// File: rtl/cacheline_mem_arbiter_n_picker.sv
// rtl/cacheline_mem_arbiter_n_picker.sv - combinational round-robin / fixed priority picker
module rr_priority_picker
  import cacheline_mem_arbiter_n_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);
  int   p_scan;
  logic found;

  // RR scans upward from ptr inclusive with wrap; fixed mode picks the highest requester.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    p_scan = 0;
    if (mode == ARB_RR) begin
      for (int k = 0; k < N; k++) begin
        p_scan = (int'(ptr) + k) % N;
        if (!found && req[p_scan]) begin
          found = 1'b1;
          idx   = IDX_W'(p_scan);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (!found && req[k]) begin
          found = 1'b1;
          idx   = IDX_W'(k);
        end
      end
    end
    if (found) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/cacheline_mem_arbiter_n.sv
// rtl/cacheline_mem_arbiter_n.sv - N-port cache-miss arbiter onto one cacheline memory port
module cacheline_mem_arbiter_n
  import cacheline_mem_arbiter_n_pkg::*;
#(
  parameter int                   NUM_PORTS  = 2,
  parameter int                   ADDR_W     = 32,
  parameter int                   LINE_W     = 256,
  parameter int                   RR_MODE    = 1,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = {{(NUM_PORTS-1){1'b0}}, 1'b1}
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  output logic invalid_cpu_request,
  cacheline_mem_arbiter_n_if.slave bus
);
  localparam int        IDX_W = idx_width(NUM_PORTS);
  localparam arb_mode_e MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, ptr_q, scan_start, pick_idx;
  logic                 fresh_q, write_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [NUM_PORTS-1:0] req_any, eligible, pick_grant;
  logic                 abandon, done;

  assign invalid_cpu_request = flush;
  assign req_any  = bus.req_read | bus.req_write;
  assign eligible = req_any & ~(flush ? FLUSH_MASK : '0);

  // Right after reset the scan starts at the pointer itself so the top port (D$) wins
  // the first tie; afterwards it starts one past the last granted port.
  assign scan_start = fresh_q ? ptr_q :
                      (ptr_q == IDX_W'(NUM_PORTS - 1)) ? '0 : ptr_q + 1'b1;

  rr_priority_picker #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
    .req   (eligible),
    .ptr   (scan_start),
    .mode  (MODE),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Only reads from flush-masked ports may be abandoned; writes always finish.
  assign abandon = flush && !write_q && FLUSH_MASK[gnt_q];
  assign done    = bus.cla_resp && (write_q || (bus.cla_raddr == addr_q));

  // Next-state, memory-side drive and response demux.
  always_comb begin
    state_d        = state_q;
    bus.cla_read   = 1'b0;
    bus.cla_write  = 1'b0;
    bus.cla_addr   = '0;
    bus.cla_wdata  = '0;
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|pick_grant) state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        bus.cla_read  = !write_q;
        bus.cla_write = write_q;
        bus.cla_addr  = addr_q;
        bus.cla_wdata = wdata_q;
        if (abandon) begin
          // A response landing with the flush is simply dropped.
          state_d = bus.cla_resp ? ARB_IDLE : ARB_DRAIN;
        end else if (done) begin
          bus.resp_valid[gnt_q] = 1'b1;
          bus.resp_rdata        = write_q ? '0 : bus.cla_rdata;
          state_d               = ARB_IDLE;
        end
      end
      ARB_DRAIN: begin
        // The read is already in flight at memory; wait it out without reporting it.
        bus.cla_read = 1'b1;
        bus.cla_addr = addr_q;
        if (bus.cla_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register, rr pointer and latching of the granted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IDX_W'(NUM_PORTS - 1);
      fresh_q <= 1'b1;
      gnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && (|pick_grant)) begin
        gnt_q   <= pick_idx;
        ptr_q   <= pick_idx;
        fresh_q <= 1'b0;
        write_q <= bus.req_write[pick_idx];
        addr_q  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
        wdata_q <= bus.req_wdata[pick_idx*LINE_W +: LINE_W];
      end
    end
  end

  // A port raising read and write together is served as a write but flagged here.
  assert property (@(posedge clk) disable iff (rst) !(|(bus.req_read & bus.req_write)));
endmodule

// File: tb/tb_cacheline_mem_arbiter_n.sv
// tb/tb_cacheline_mem_arbiter_n.sv - directed self-checking bench for cacheline_mem_arbiter_n
module tb_cacheline_mem_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_b = 1'b0;
  logic inv_a, inv_b;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  localparam logic [255:0] LINE_A  = {8{32'hA5A5_0100}};
  localparam logic [255:0] LINE_W1 = {8{32'h0BAD_0300}};
  localparam logic [255:0] LINE_W2 = {8{32'h1234_5678}};
  localparam logic [255:0] LINE_B  = {8{32'hCAFE_F00D}};

  always #5 clk = ~clk;

  cacheline_mem_arbiter_n_if #(.NUM_PORTS(2), .ADDR_W(32), .LINE_W(256)) ifa ();
  cacheline_mem_arbiter_n_if #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(32))  ifb ();

  cacheline_mem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(32), .LINE_W(256), .RR_MODE(1),
                            .FLUSH_MASK(2'b01)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .invalid_cpu_request(inv_a), .bus(ifa.slave));

  cacheline_mem_arbiter_n #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(32), .RR_MODE(1),
                            .FLUSH_MASK(4'b0001)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .invalid_cpu_request(inv_b), .bus(ifb.slave));

  task automatic clear_inputs();
    flush = 1'b0; flush_b = 1'b0;
    ifa.req_addr = '0; ifa.req_read = '0; ifa.req_write = '0; ifa.req_wdata = '0;
    ifa.cla_rdata = '0; ifa.cla_raddr = '0; ifa.cla_resp = 1'b0;
    ifb.req_addr = '0; ifb.req_read = '0; ifb.req_write = '0; ifb.req_wdata = '0;
    ifb.cla_rdata = '0; ifb.cla_raddr = '0; ifb.cla_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (ifa.cla_read !== 1'b0 || ifa.cla_write !== 1'b0) $display("FAIL reset_cla_rw got %0b%0b exp 00", ifa.cla_read, ifa.cla_write); else pass_cnt++;
    total_cnt++; if (ifa.cla_addr !== 32'h0) $display("FAIL reset_cla_addr got %h exp 0", ifa.cla_addr); else pass_cnt++;
    total_cnt++; if (ifa.resp_valid !== 2'b00 || ifa.resp_rdata !== '0) $display("FAIL reset_resp got %b exp 00", ifa.resp_valid); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (inv_a !== 1'b0 || ifb.cla_read !== 1'b0) $display("FAIL reset_idle got inv=%0b rd4=%0b exp 0 0", inv_a, ifb.cla_read); else pass_cnt++;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    ifa.req_addr[31:0] = 32'h100; ifa.req_read = 2'b01;
    #1;
    total_cnt++; if (ifa.cla_read !== 1'b0) $display("FAIL t1_not_yet got %0b exp 0", ifa.cla_read); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (ifa.cla_read !== 1'b1) $display("FAIL t1_cla_read got %0b exp 1", ifa.cla_read); else pass_cnt++;
    total_cnt++; if (ifa.cla_addr !== 32'h100) $display("FAIL t1_cla_addr got %h exp 100", ifa.cla_addr); else pass_cnt++;
    ifa.cla_resp = 1'b1; ifa.cla_raddr = 32'h100; ifa.cla_rdata = LINE_A;
    #1;
    total_cnt++; if (ifa.resp_valid !== 2'b01) $display("FAIL t1_resp_valid got %b exp 01", ifa.resp_valid); else pass_cnt++;
    total_cnt++; if (ifa.resp_rdata !== LINE_A) $display("FAIL t1_rdata got %h exp %h", ifa.resp_rdata[31:0], LINE_A[31:0]); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b0; ifa.req_read = 2'b00;
    #1;
    total_cnt++; if (ifa.cla_read !== 1'b0 || ifa.resp_valid !== 2'b00) $display("FAIL t1_back_idle got rd=%0b rv=%b exp 0 00", ifa.cla_read, ifa.resp_valid); else pass_cnt++;
  endtask

  task automatic test_rr_alternation();
    logic [31:0] exp_addr;
    logic [1:0]  exp_rv;
    do_reset();
    @(negedge clk);
    ifa.req_addr = {32'h200, 32'h100}; ifa.req_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h200 : 32'h100;
      exp_rv   = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk); #1;
      total_cnt++; if (ifa.cla_addr !== exp_addr || ifa.cla_read !== 1'b1) $display("FAIL t2_grant%0d_addr got %h exp %h", i, ifa.cla_addr, exp_addr); else pass_cnt++;
      ifa.cla_resp = 1'b1; ifa.cla_raddr = exp_addr; ifa.cla_rdata = {8{exp_addr}};
      #1;
      total_cnt++; if (ifa.resp_valid !== exp_rv) $display("FAIL t2_grant%0d_rv got %b exp %b", i, ifa.resp_valid, exp_rv); else pass_cnt++;
      total_cnt++; if (ifa.resp_rdata !== {8{exp_addr}}) $display("FAIL t2_grant%0d_rdata got %h exp %h", i, ifa.resp_rdata[31:0], exp_addr); else pass_cnt++;
      @(negedge clk);
      ifa.cla_resp = 1'b0;
    end
    ifa.req_read = 2'b00;
  endtask

  task automatic test_flush_drain();
    do_reset();
    @(negedge clk);
    ifa.req_addr[31:0] = 32'h100; ifa.req_read = 2'b01;
    @(negedge clk);
    ifa.req_addr[63:32] = 32'h300; ifa.req_wdata[511:256] = LINE_W1; ifa.req_write = 2'b10;
    flush = 1'b1;
    #1;
    total_cnt++; if (inv_a !== 1'b1 || ifa.cla_read !== 1'b1) $display("FAIL t3_busy_flush got inv=%0b rd=%0b exp 1 1", inv_a, ifa.cla_read); else pass_cnt++;
    @(negedge clk);
    flush = 1'b0; ifa.req_read = 2'b00;
    #1;
    total_cnt++; if (ifa.cla_read !== 1'b1 || ifa.cla_addr !== 32'h100) $display("FAIL t3_drain_read got rd=%0b addr=%h exp 1 100", ifa.cla_read, ifa.cla_addr); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b1; ifa.cla_raddr = 32'h100; ifa.cla_rdata = LINE_B;
    #1;
    total_cnt++; if (ifa.resp_valid !== 2'b00) $display("FAIL t3_drain_no_rv got %b exp 00", ifa.resp_valid); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b0;
    #1;
    total_cnt++; if (ifa.cla_read !== 1'b0 || ifa.cla_write !== 1'b0) $display("FAIL t3_idle_after got %0b%0b exp 00", ifa.cla_read, ifa.cla_write); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (ifa.cla_write !== 1'b1 || ifa.cla_addr !== 32'h300 || ifa.cla_wdata !== LINE_W1) $display("FAIL t3_dwrite_grant got wr=%0b addr=%h exp 1 300", ifa.cla_write, ifa.cla_addr); else pass_cnt++;
    ifa.cla_resp = 1'b1;
    #1;
    total_cnt++; if (ifa.resp_valid !== 2'b10) $display("FAIL t3_dwrite_rv got %b exp 10", ifa.resp_valid); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b0; ifa.req_write = 2'b00;
  endtask

  task automatic test_write_flush();
    do_reset();
    @(negedge clk);
    ifa.req_addr[63:32] = 32'h400; ifa.req_wdata[511:256] = LINE_W2; ifa.req_write = 2'b10;
    @(negedge clk);
    flush = 1'b1; ifa.req_wdata[511:256] = LINE_B;
    #1;
    total_cnt++; if (ifa.cla_write !== 1'b1 || ifa.cla_wdata !== LINE_W2) $display("FAIL t4_write_busy got wr=%0b wd=%h exp 1 %h", ifa.cla_write, ifa.cla_wdata[31:0], LINE_W2[31:0]); else pass_cnt++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total_cnt++; if (ifa.cla_write !== 1'b1 || ifa.cla_wdata !== LINE_W2) $display("FAIL t4_write_stable got wr=%0b wd=%h exp 1 %h", ifa.cla_write, ifa.cla_wdata[31:0], LINE_W2[31:0]); else pass_cnt++;
    @(negedge clk);
    flush = 1'b1; ifa.cla_resp = 1'b1; ifa.cla_raddr = 32'hDEAD;
    #1;
    total_cnt++; if (ifa.resp_valid !== 2'b10) $display("FAIL t4_write_done got %b exp 10", ifa.resp_valid); else pass_cnt++;
    @(negedge clk);
    flush = 1'b0; ifa.cla_resp = 1'b0; ifa.req_write = 2'b00;
    #1;
    total_cnt++; if (ifa.cla_write !== 1'b0) $display("FAIL t4_idle got %0b exp 0", ifa.cla_write); else pass_cnt++;
  endtask

  task automatic test_raddr_mismatch();
    do_reset();
    @(negedge clk);
    ifa.req_addr[31:0] = 32'h100; ifa.req_read = 2'b01;
    @(negedge clk);
    ifa.cla_resp = 1'b1; ifa.cla_raddr = 32'h200; ifa.cla_rdata = LINE_A;
    #1;
    total_cnt++; if (ifa.resp_valid !== 2'b00) $display("FAIL t5_mismatch_rv got %b exp 00", ifa.resp_valid); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b0;
    #1;
    total_cnt++; if (ifa.cla_read !== 1'b1 || ifa.cla_addr !== 32'h100) $display("FAIL t5_still_busy got rd=%0b addr=%h exp 1 100", ifa.cla_read, ifa.cla_addr); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b1; ifa.cla_raddr = 32'h100; ifa.cla_rdata = LINE_B;
    #1;
    total_cnt++; if (ifa.resp_valid !== 2'b01 || ifa.resp_rdata !== LINE_B) $display("FAIL t5_match_done got rv=%b rd=%h exp 01 %h", ifa.resp_valid, ifa.resp_rdata[31:0], LINE_B[31:0]); else pass_cnt++;
    @(negedge clk);
    ifa.cla_resp = 1'b0; ifa.req_read = 2'b00;
  endtask

  task automatic test_four_port_rr_and_reset();
    int          order [5];
    logic [31:0] exp_addr;
    order = '{3, 0, 1, 2, 3};
    do_reset();
    @(negedge clk);
    for (int p = 0; p < 4; p++) ifb.req_addr[p*32 +: 32] = 32'h1000 + 32'(p) * 32'h40;
    ifb.req_read = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_addr = 32'h1000 + 32'(order[i]) * 32'h40;
      @(negedge clk); #1;
      total_cnt++; if (ifb.cla_addr !== exp_addr || ifb.cla_read !== 1'b1) $display("FAIL t6_grant%0d_addr got %h exp %h", i, ifb.cla_addr, exp_addr); else pass_cnt++;
      ifb.cla_resp = 1'b1; ifb.cla_raddr = exp_addr; ifb.cla_rdata = 32'(order[i]) + 32'h50;
      #1;
      total_cnt++; if (ifb.resp_valid !== 4'(1 << order[i]) || ifb.resp_rdata !== 32'(order[i]) + 32'h50) $display("FAIL t6_grant%0d_rv got %b exp %b", i, ifb.resp_valid, 4'(1 << order[i])); else pass_cnt++;
      @(negedge clk);
      ifb.cla_resp = 1'b0;
    end
    @(negedge clk); #1;
    total_cnt++; if (ifb.cla_read !== 1'b1 || ifb.cla_addr !== 32'h1000) $display("FAIL t6_busy_before_rst got rd=%0b addr=%h exp 1 1000", ifb.cla_read, ifb.cla_addr); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (ifb.cla_read !== 1'b0 || ifb.cla_addr !== 32'h0 || ifb.resp_valid !== 4'b0) $display("FAIL t6_after_rst got rd=%0b addr=%h rv=%b exp 0 0 0", ifb.cla_read, ifb.cla_addr, ifb.resp_valid); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (ifb.cla_addr !== 32'h10C0) $display("FAIL t6_regrant_top got %h exp 10c0", ifb.cla_addr); else pass_cnt++;
    ifb.req_read = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_alternation();
    test_flush_drain();
    test_write_flush();
    test_raddr_mismatch();
    test_four_port_rr_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
